// File: rtl/sample_fetch_fsm.sv
// sample_fetch_fsm
// Reads 32-bit words from flash over an Avalon-MM read master. Each word is
// played out as two 16-bit samples, one per rising edge of the sample tick.
// The block supports play/pause, forward/reverse playback, restart and
// address wrap-around.
module sample_fetch_fsm #(
  parameter int                    ADDR_WIDTH = 23,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAX   = 23'h7FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  play_en,
  input  logic                  direction,
  input  logic                  restart,
  output logic                  flash_read,
  output logic [ADDR_WIDTH-1:0] flash_address,
  input  logic                  flash_waitrequest,
  input  logic [31:0]           flash_readdata,
  input  logic                  flash_readdatavalid,
  output logic [15:0]           audio_out,
  output logic                  audio_valid,
  output logic                  underrun
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ_REQ   = 3'd1,
    ST_READ_WAIT  = 3'd2,
    ST_OUT_FIRST  = 3'd3,
    ST_OUT_SECOND = 3'd4,
    ST_ADVANCE    = 3'd5
  } state_t;

  // First word address of the playback direction (forward starts at 0,
  // reverse starts at the top of the image).
  function automatic logic [ADDR_WIDTH-1:0] start_addr(input logic dir);
    if (dir) begin
      return ADDR_MAX;
    end else begin
      return ADDR_ZERO;
    end
  endfunction

  // Next word address in the given direction, wrapping at both ends.
  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic dir);
    if (dir) begin
      if (a == ADDR_ZERO) begin
        return ADDR_MAX;
      end else begin
        return a - ADDR_ONE;
      end
    end else begin
      if (a == ADDR_MAX) begin
        return ADDR_ZERO;
      end else begin
        return a + ADDR_ONE;
      end
    end
  endfunction

  // Selects one half of a captured word.
  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic upper);
    if (upper) begin
      return word[31:16];
    end else begin
      return word[15:0];
    end
  endfunction

  state_t                  state_r;
  state_t                  next_state_s;

  logic                    tick_d_r;
  logic                    tick_evt_s;
  logic                    tick_play_s;
  logic                    discard_s;

  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ADDR_WIDTH-1:0]   addr_nxt_s;
  logic [31:0]             word_r;
  logic [31:0]             word_nxt_s;
  logic                    upper_first_r;
  logic                    upper_first_nxt_s;
  logic                    restart_pending_r;
  logic                    restart_pending_nxt_s;

  logic                    flash_read_r;
  logic                    flash_read_nxt_s;
  logic [15:0]             audio_out_r;
  logic [15:0]             audio_out_nxt_s;
  logic                    audio_valid_r;
  logic                    audio_valid_nxt_s;
  logic                    underrun_r;
  logic                    underrun_nxt_s;

  // A tick counts once, on the cycle it rises.
  assign tick_evt_s  = sample_tick & ~tick_d_r;
  assign tick_play_s = tick_evt_s & play_en;
  // Returned data is thrown away if a restart is pending or arrives with it.
  assign discard_s   = restart_pending_r | restart;

  assign flash_read    = flash_read_r;
  assign flash_address = addr_r;
  assign audio_out     = audio_out_r;
  assign audio_valid   = audio_valid_r;
  assign underrun      = underrun_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (play_en) begin
          next_state_s = ST_READ_REQ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_READ_REQ: begin
        if (flash_waitrequest) begin
          next_state_s = ST_READ_REQ;
        end else begin
          next_state_s = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        if (flash_readdatavalid) begin
          if (discard_s) begin
            next_state_s = ST_READ_REQ;
          end else begin
            next_state_s = ST_OUT_FIRST;
          end
        end else begin
          next_state_s = ST_READ_WAIT;
        end
      end
      ST_OUT_FIRST, ST_OUT_SECOND: begin
        if (restart) begin
          if (play_en) begin
            next_state_s = ST_READ_REQ;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else if (tick_play_s) begin
          if (state_r == ST_OUT_FIRST) begin
            next_state_s = ST_OUT_SECOND;
          end else begin
            next_state_s = ST_ADVANCE;
          end
        end else begin
          next_state_s = state_r;
        end
      end
      ST_ADVANCE: begin
        if (play_en) begin
          next_state_s = ST_READ_REQ;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output and datapath decode: next values for every registered output.
  always_comb begin
    addr_nxt_s            = addr_r;
    word_nxt_s            = word_r;
    upper_first_nxt_s     = upper_first_r;
    restart_pending_nxt_s = restart_pending_r;
    audio_out_nxt_s       = audio_out_r;
    audio_valid_nxt_s     = 1'b0;
    underrun_nxt_s        = 1'b0;

    // The request is raised with the state so address and read align.
    if (next_state_s == ST_READ_REQ) begin
      flash_read_nxt_s = 1'b1;
    end else begin
      flash_read_nxt_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (restart) begin
          addr_nxt_s = start_addr(direction);
        end else begin
          addr_nxt_s = addr_r;
        end
      end
      ST_READ_REQ: begin
        // The request is never withdrawn; a restart re-points the address
        // and marks whatever comes back as stale.
        if (restart) begin
          addr_nxt_s            = start_addr(direction);
          restart_pending_nxt_s = 1'b1;
        end else if (tick_play_s) begin
          underrun_nxt_s = 1'b1;
        end else begin
          underrun_nxt_s = 1'b0;
        end
      end
      ST_READ_WAIT: begin
        if (restart) begin
          addr_nxt_s = start_addr(direction);
        end else if (tick_play_s) begin
          underrun_nxt_s = 1'b1;
        end else begin
          underrun_nxt_s = 1'b0;
        end
        if (flash_readdatavalid) begin
          if (discard_s) begin
            restart_pending_nxt_s = 1'b0;
          end else begin
            word_nxt_s        = flash_readdata;
            upper_first_nxt_s = direction;
          end
        end else if (restart) begin
          restart_pending_nxt_s = 1'b1;
        end else begin
          restart_pending_nxt_s = restart_pending_r;
        end
      end
      ST_OUT_FIRST, ST_OUT_SECOND: begin
        if (restart) begin
          addr_nxt_s = start_addr(direction);
        end else if (tick_play_s) begin
          // Second half is the opposite of the first half.
          if (state_r == ST_OUT_FIRST) begin
            audio_out_nxt_s = pick_half(word_r, upper_first_r);
          end else begin
            audio_out_nxt_s = pick_half(word_r, ~upper_first_r);
          end
          audio_valid_nxt_s = 1'b1;
        end else begin
          audio_valid_nxt_s = 1'b0;
        end
      end
      ST_ADVANCE: begin
        if (restart) begin
          addr_nxt_s = start_addr(direction);
        end else begin
          addr_nxt_s = step_addr(addr_r, direction);
          if (tick_play_s) begin
            underrun_nxt_s = 1'b1;
          end else begin
            underrun_nxt_s = 1'b0;
          end
        end
      end
      default: begin
        addr_nxt_s = addr_r;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_d_r          <= 1'b0;
      addr_r            <= ADDR_ZERO;
      word_r            <= 32'h0000_0000;
      upper_first_r     <= 1'b0;
      restart_pending_r <= 1'b0;
      flash_read_r      <= 1'b0;
      audio_out_r       <= 16'h0000;
      audio_valid_r     <= 1'b0;
      underrun_r        <= 1'b0;
    end else begin
      tick_d_r          <= sample_tick;
      addr_r            <= addr_nxt_s;
      word_r            <= word_nxt_s;
      upper_first_r     <= upper_first_nxt_s;
      restart_pending_r <= restart_pending_nxt_s;
      flash_read_r      <= flash_read_nxt_s;
      audio_out_r       <= audio_out_nxt_s;
      audio_valid_r     <= audio_valid_nxt_s;
      underrun_r        <= underrun_nxt_s;
    end
  end

endmodule

// File: doc/sample_fetch_fsm.md
Name: sample_fetch_fsm

Overview:
Downstream consumer of the sample-rate synchronizer. Takes the synchronized sample-rate strobe in the system clock domain and fetches 32-bit words from flash over an Avalon-MM read master. Each word is split into two 16-bit audio samples, presented one per strobe. Supports play/pause, forward/reverse playback, restart and address wrap-around.

Parameters:
ADDR_WIDTH, 23, width of flash word address
ADDR_MAX, 23'h7FFFF, last valid word address (inclusive)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
sample_tick  input  1  synchronized sample-rate strobe; already in clk domain
play_en  input  1  1 = play, 0 = pause
direction  input  1  0 = forward, 1 = reverse
restart  input  1  single-cycle pulse; jump to start of current direction
flash_read  output  1  Avalon read request
flash_address  output  ADDR_WIDTH  Avalon word address
flash_waitrequest  input  1  Avalon wait request
flash_readdata  input  32  Avalon read data
flash_readdatavalid  input  1  Avalon read data valid
audio_out  output  16  current sample, two's complement, held between updates
audio_valid  output  1  one-cycle pulse when audio_out updates
underrun  output  1  one-cycle pulse when a tick arrives with no sample ready

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE, addr 0
  - flash_read 0, flash_address 0
  - audio_out 0, audio_valid 0, underrun 0
  - tick edge register 0, restart_pending 0
- Tick event: rising edge of sample_tick (high this cycle, low last cycle). A tick held high for several cycles counts once. Ticks are at least 2 cycles apart.
- flash_address always equals the internal addr register.
- States:
  - IDLE: flash_read 0. If play_en -> READ_REQ.
  - READ_REQ: flash_read 1. Stay while flash_waitrequest=1. When waitrequest=0 -> READ_WAIT. flash_read drops the next cycle.
  - READ_WAIT: wait for flash_readdatavalid.
    - If restart_pending: discard the data, clear the flag, -> READ_REQ.
    - Otherwise: capture the word and latch the half order from direction, -> OUT_FIRST.
    - Forward order: [15:0] then [31:16]. Reverse order: [31:16] then [15:0].
  - OUT_FIRST: on a tick event with play_en=1, emit the first half, -> OUT_SECOND.
  - OUT_SECOND: on a tick event with play_en=1, emit the second half, -> ADVANCE.
  - ADVANCE: one cycle, then update addr:
    - Forward: addr==ADDR_MAX ? 0 : addr+1.
    - Reverse: addr==0 ? ADDR_MAX : addr-1.
    - Then -> READ_REQ if play_en, else IDLE.
- Emit: audio_out and audio_valid are registered and update on the cycle after the tick-event cycle. audio_valid is high for exactly that one cycle.
- Pause (play_en=0):
  - Ticks in OUT_* are ignored; audio_out holds and no underrun is raised.
  - An in-flight read completes normally.
- Underrun: a tick event with play_en=1 in READ_REQ, READ_WAIT or ADVANCE gives underrun=1 on the next cycle. That sample is skipped and audio_out holds.
- Restart:
  - addr <= 0 if direction=0, else ADDR_MAX.
  - In READ_REQ/READ_WAIT: the Avalon transaction is never abandoned; set restart_pending and use the READ_WAIT discard path. If restart arrives in READ_REQ before waitrequest drops, addr is updated immediately and the pending request carries the new address; restart_pending is still set.
  - In OUT_*/ADVANCE/IDLE: go to READ_REQ if play_en, else IDLE.
  - A simultaneous tick and restart: restart wins and no sample is emitted.
- Direction change:
  - Affects the next addr step and the next captured word's half order.
  - Never reorders a word already captured.

Test Plan:
- Reset then play_en=1, direction=0; flash returns 32'hBBBB_AAAA at addr 0 with waitrequest=0 -> first tick gives audio_out=16'hAAAA, second tick 16'hBBBB; then flash_read with flash_address=1.
- Reverse with ADDR_MAX=3, addr=0 after restart in direction=1: restart sets addr=3; after 2 ticks addr goes 3->2. Forward from addr=3: after 2 ticks addr wraps to 0.
- Hold waitrequest=1 for 5 cycles and readdatavalid 3 cycles later; tick arrives during the wait -> underrun pulse for 1 cycle, audio_out unchanged, no second read issued.
- play_en=0 in OUT_SECOND, 4 ticks -> no audio_valid, no underrun; play_en=1 then a tick -> second half emitted.
- restart during READ_WAIT at addr 5 -> returned data discarded (no audio_valid), next flash_read at address 0.
- Assert reset mid-READ_REQ -> flash_read, audio_out and flash_address go to 0 immediately, without waiting for a clock edge.
